// File: rtl/ddr3_mem_resp.sv
// DDR3 device-side responder: command decode, per-bank row/tRCD tracking and a
// single-outstanding read/write burst engine over a 128 x 8-byte array.
module ddr3_mem_resp #(
    parameter int CL   = 5,
    parameter int CWL  = 5,
    parameter int TRCD = 4
) (
    input  logic        cpu_clk,
    input  logic        RESET,
    input  logic        CKE,
    input  logic        CS_N,
    input  logic        RAS_N,
    input  logic        CAS_N,
    input  logic        WE_N,
    input  logic [2:0]  BA,
    input  logic [14:0] ADDR,
    input  logic [7:0]  DQ_IN,
    output logic [7:0]  DQ_OUT,
    output logic        DQ_OE,
    output logic [7:0]  BANK_OPEN,
    output logic [14:0] MR0,
    output logic        ERR
);
    localparam int NB    = 8;
    localparam int LAT   = (CL > CWL) ? CL : CWL;
    localparam int LAT_W = $clog2(LAT + 1);
    localparam int RCD_W = $clog2(TRCD + 2);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST} eng_state_t;

    typedef struct packed {
        logic act;
        logic rd;
        logic wr;
        logic pre;
        logic refr;
        logic mrs;
    } cmd_t;

    cmd_t                    cmd;
    eng_state_t              state;
    logic [LAT_W-1:0]        lat_cnt;
    logic [2:0]              beat;
    logic [6:0]              cur_idx;
    logic [NB-1:0][14:0]     open_row;
    logic [NB-1:0]           rcd_ok;
    logic                    act_ok, col_ok, ref_mrs_ok, pre_hit, viol;
    logic                    mem_we;
    logic [9:0]              mem_waddr;
    logic [7:0]              mem [1024];

    always_comb begin
        cmd = '0;
        if (CKE && !CS_N) begin
            case ({RAS_N, CAS_N, WE_N})
                3'b011:  cmd.act  = 1'b1;
                3'b101:  cmd.rd   = 1'b1;
                3'b100:  cmd.wr   = 1'b1;
                3'b010:  cmd.pre  = 1'b1;
                3'b001:  cmd.refr = 1'b1;
                3'b000:  cmd.mrs  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        act_ok     = cmd.act && !BANK_OPEN[BA];
        col_ok     = (cmd.rd || cmd.wr) && state == IDLE && BANK_OPEN[BA] && rcd_ok[BA];
        ref_mrs_ok = (cmd.refr || cmd.mrs) && BANK_OPEN == '0 && state == IDLE;
        pre_hit    = cmd.pre && state != IDLE && (ADDR[10] || BA == cur_idx[6:4]);
        viol       = (cmd.act && BANK_OPEN[BA]) ||
                     ((cmd.rd || cmd.wr) && !col_ok) ||
                     ((cmd.refr || cmd.mrs) && !ref_mrs_ok) ||
                     pre_hit;
    end

    // The counter reads 1 on the edge TRCD cycles after ACT; that edge already
    // satisfies tRCD, since the counter reaches 0 on it.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [RCD_W-1:0] rcd_cnt;
        always_ff @(posedge cpu_clk or posedge RESET) begin
            if (RESET)
                rcd_cnt <= '0;
            else if (act_ok && BA == 3'(b))
                rcd_cnt <= RCD_W'(TRCD);
            else if (rcd_cnt != '0)
                rcd_cnt <= rcd_cnt - RCD_W'(1);
        end
        assign rcd_ok[b] = (rcd_cnt <= RCD_W'(1));
    end

    always_ff @(posedge cpu_clk or posedge RESET) begin
        if (RESET) begin
            BANK_OPEN <= '0;
            open_row  <= '0;
            MR0       <= '0;
            ERR       <= 1'b0;
            DQ_OE     <= 1'b0;
            DQ_OUT    <= '0;
            state     <= IDLE;
            lat_cnt   <= '0;
            beat      <= '0;
            cur_idx   <= '0;
        end else begin
            if (viol)
                ERR <= 1'b1;
            if (act_ok) begin
                BANK_OPEN[BA] <= 1'b1;
                open_row[BA]  <= ADDR;
            end
            if (cmd.pre) begin
                if (ADDR[10])
                    BANK_OPEN <= '0;
                else
                    BANK_OPEN[BA] <= 1'b0;
            end
            if (cmd.mrs && ref_mrs_ok && BA == 3'd0)
                MR0 <= ADDR;

            DQ_OE  <= 1'b0;
            DQ_OUT <= '0;
            case (state)
                IDLE: if (col_ok) begin
                    cur_idx <= {BA, ADDR[6:3]};
                    lat_cnt <= cmd.rd ? LAT_W'(CL - 1) : LAT_W'(CWL - 1);
                    state   <= cmd.rd ? RD_WAIT : WR_WAIT;
                end
                RD_WAIT: if (lat_cnt == '0) begin
                    state  <= RD_BURST;
                    DQ_OE  <= 1'b1;
                    DQ_OUT <= mem[{cur_idx, 3'd0}];
                    beat   <= 3'd1;
                end else
                    lat_cnt <= lat_cnt - LAT_W'(1);
                // Going IDLE while the last beat is loaded lets a new column
                // command land on the very next edge.
                RD_BURST: begin
                    DQ_OE  <= 1'b1;
                    DQ_OUT <= mem[{cur_idx, beat}];
                    beat   <= beat + 3'd1;
                    if (beat == 3'd7)
                        state <= IDLE;
                end
                WR_WAIT: if (lat_cnt == '0) begin
                    state <= WR_BURST;
                    beat  <= 3'd1;
                end else
                    lat_cnt <= lat_cnt - LAT_W'(1);
                WR_BURST: begin
                    beat <= beat + 3'd1;
                    if (beat == 3'd7)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately outside reset: committed beats survive RESET.
    assign mem_we    = (state == WR_WAIT && lat_cnt == '0) || state == WR_BURST;
    assign mem_waddr = {cur_idx, (state == WR_BURST) ? beat : 3'd0};

    always_ff @(posedge cpu_clk) begin
        if (mem_we)
            mem[mem_waddr] <= DQ_IN;
    end
endmodule

// File: tb/tb_ddr3_mem_resp.sv
// Randomized + directed bench for ddr3_mem_resp against a cycle-indexed
// reference model (timestamps per bank/burst, byte array for storage).
module tb_ddr3_mem_resp;
    localparam int CL = 5, CWL = 5, TRCD = 4;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                           C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

    logic        cpu_clk = 1'b0;
    logic        RESET, CKE, CS_N, RAS_N, CAS_N, WE_N;
    logic [2:0]  BA;
    logic [14:0] ADDR;
    logic [7:0]  DQ_IN, DQ_OUT, BANK_OPEN;
    logic        DQ_OE, ERR;
    logic [14:0] MR0;

    int n_chk = 0, n_err = 0;

    ddr3_mem_resp #(.CL(CL), .CWL(CWL), .TRCD(TRCD)) dut (
        .cpu_clk(cpu_clk), .RESET(RESET), .CKE(CKE), .CS_N(CS_N), .RAS_N(RAS_N),
        .CAS_N(CAS_N), .WE_N(WE_N), .BA(BA), .ADDR(ADDR), .DQ_IN(DQ_IN),
        .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .BANK_OPEN(BANK_OPEN), .MR0(MR0), .ERR(ERR)
    );

    always #5 cpu_clk = ~cpu_clk;

    // reference model state
    bit          m_open [8];
    int          m_act [8];
    int          m_busy, m_t, m_idx, cyc;
    bit          m_err, m_rd, m_wr;
    logic [14:0] m_mr0;
    logic [7:0]  m_mem [1024];
    bit          e_oe;
    logic [7:0]  e_dq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] open_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_open[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_act[i] = -1000; end
        m_busy = 0; m_err = 0; m_mr0 = '0; m_rd = 0; m_wr = 0;
        e_oe = 0; e_dq = '0;
    endtask

    task automatic model_step();
        int e, b;
        logic [2:0] c;
        cyc++;
        e = cyc;
        if (e >= m_busy) begin m_rd = 0; m_wr = 0; end
        e_oe = 0; e_dq = '0;
        if (m_rd && e >= m_t + CL && e <= m_t + CL + 7) begin
            e_oe = 1;
            e_dq = m_mem[m_idx * 8 + e - m_t - CL];
        end
        if (m_wr && e >= m_t + CWL && e <= m_t + CWL + 7)
            m_mem[m_idx * 8 + e - m_t - CWL] = DQ_IN;
        if (CKE && !CS_N) begin
            c = {RAS_N, CAS_N, WE_N};
            b = int'(BA);
            case (c)
                C_ACT: if (m_open[b]) m_err = 1;
                       else begin m_open[b] = 1; m_act[b] = e; end
                C_RD, C_WR:
                    if (m_open[b] && e >= m_act[b] + TRCD && e >= m_busy) begin
                        m_rd = (c == C_RD); m_wr = (c == C_WR); m_t = e;
                        m_idx = b * 16 + int'(ADDR[6:3]);
                        m_busy = e + ((c == C_RD) ? CL : CWL) + 8;
                    end else m_err = 1;
                C_PRE: begin
                    if (e < m_busy && (ADDR[10] || b == m_idx / 16)) m_err = 1;
                    if (ADDR[10]) for (int i = 0; i < 8; i++) m_open[i] = 0;
                    else m_open[b] = 0;
                end
                C_REF, C_MRS:
                    if (open_vec() != 0 || e < m_busy) m_err = 1;
                    else if (c == C_MRS && b == 0) m_mr0 = ADDR;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("dq_oe", 32'(DQ_OE), 32'(e_oe));
        chk("dq_out", 32'(DQ_OUT), 32'(e_dq));
        chk("bank_open", 32'(BANK_OPEN), 32'(open_vec()));
        chk("err", 32'(ERR), 32'(m_err));
        chk("mr0", 32'(MR0), 32'(m_mr0));
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        if (!RESET) model_step();
        #1 check_all();
        @(negedge cpu_clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
        CS_N = 1'b0; {RAS_N, CAS_N, WE_N} = c; BA = ba; ADDR = a;
        tick();
        CS_N = 1'b1; {RAS_N, CAS_N, WE_N} = C_NOP;
    endtask

    task automatic nops(input int n);
        repeat (n) begin DQ_IN = 8'($urandom); tick(); end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1 model_reset();
        check_all();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int oe_cnt, r;
        RESET = 1'b1; CKE = 1'b1; CS_N = 1'b1; {RAS_N, CAS_N, WE_N} = C_NOP;
        BA = '0; ADDR = '0; DQ_IN = '0; cyc = 0;
        model_reset();
        @(negedge cpu_clk);
        chk("rst_bank_open", 32'(BANK_OPEN), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_dq_oe", 32'(DQ_OE), 0);
        tick();
        RESET = 1'b0;

        // fill every burst through the write path, back-to-back writes
        for (int b = 0; b < 8; b++) begin
            issue(C_ACT, 3'(b), 15'(b * 3 + 1));
            nops(TRCD - 1);
            for (int c = 0; c < 16; c++) begin
                DQ_IN = 8'($urandom);
                issue(C_WR, 3'(b), 15'(c << 3));
                nops(CWL + 7);
            end
            issue(C_PRE, 3'(b), 15'h0);
        end

        // RD too soon after ACT
        do_reset();
        issue(C_ACT, 3'd2, 15'h1A5);
        chk("act_bank_open", 32'(BANK_OPEN), 32'h04);
        nops(1);
        issue(C_RD, 3'd2, 15'h0);
        chk("trcd_err", 32'(ERR), 1);
        nops(14);

        // write then immediately read back the same burst
        do_reset();
        issue(C_ACT, 3'd1, 15'h0);
        nops(TRCD - 1);
        issue(C_WR, 3'd1, 15'h18);
        nops(CWL - 1);
        for (int i = 0; i < 8; i++) begin DQ_IN = 8'(8'h10 + i); tick(); end
        issue(C_RD, 3'd1, 15'h18);
        nops(CL - 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("raw_oe", 32'(DQ_OE), 1);
            chk("raw_data", 32'(DQ_OUT), 32'(8'h10 + i));
        end
        tick();
        chk("raw_oe_end", 32'(DQ_OE), 0);
        chk("raw_err", 32'(ERR), 0);

        // second RD while one is outstanding
        do_reset();
        issue(C_ACT, 3'd3, 15'h7);
        nops(TRCD - 1);
        issue(C_RD, 3'd3, 15'h0);
        nops(2);
        issue(C_RD, 3'd3, 15'h8);
        oe_cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (DQ_OE) oe_cnt++; end
        chk("busy_err", 32'(ERR), 1);
        chk("oe_cycles", 32'(oe_cnt), 8);

        // precharge-all then MRS
        do_reset();
        issue(C_ACT, 3'd0, 15'h11);
        issue(C_ACT, 3'd5, 15'h22);
        issue(C_PRE, 3'd0, 15'h400);
        chk("preall", 32'(BANK_OPEN), 0);
        issue(C_MRS, 3'd0, 15'h0A31);
        chk("mrs_mr0", 32'(MR0), 32'h0A31);
        chk("mrs_err", 32'(ERR), 0);

        // async reset mid-burst, then reread the same burst
        issue(C_ACT, 3'd4, 15'h3);
        nops(TRCD - 1);
        issue(C_RD, 3'd4, 15'h20);
        nops(CL + 3);
        RESET = 1'b1;
        #1;
        chk("arst_oe", 32'(DQ_OE), 0);
        chk("arst_bank_open", 32'(BANK_OPEN), 0);
        chk("arst_err", 32'(ERR), 0);
        model_reset();
        tick();
        RESET = 1'b0;
        issue(C_ACT, 3'd4, 15'h3);
        nops(TRCD - 1);
        issue(C_RD, 3'd4, 15'h20);
        nops(CL + 9);

        // CKE low masks commands
        do_reset();
        CKE = 1'b0;
        issue(C_ACT, 3'd6, 15'h55);
        CKE = 1'b1;
        chk("cke_bank_open", 32'(BANK_OPEN), 0);
        chk("cke_err", 32'(ERR), 0);

        // random command soup
        for (int p = 0; p < 20; p++) begin
            do_reset();
            repeat (100) begin
                r = $urandom_range(0, 99);
                CKE  = ($urandom_range(0, 19) != 0);
                CS_N = ($urandom_range(0, 19) == 0);
                {RAS_N, CAS_N, WE_N} = (r < 45) ? C_NOP : (r < 60) ? C_ACT : (r < 75) ? C_RD :
                                       (r < 88) ? C_WR : (r < 95) ? C_PRE : (r < 98) ? C_REF : C_MRS;
                BA = 3'($urandom_range(0, 3));
                ADDR = 15'($urandom);
                ADDR[10] = ($urandom_range(0, 9) == 0);
                DQ_IN = 8'($urandom);
                tick();
            end
            CKE = 1'b1; CS_N = 1'b1; {RAS_N, CAS_N, WE_N} = C_NOP;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr3_mem_resp.md
DDR3_MEM_RESP -- requirements
Module: ddr3_mem_resp

Interface
REQ-001 Parameters SHALL be:
- CL, default 5: read latency in cycles.
- CWL, default 5: write latency in cycles.
- TRCD, default 4: minimum cycles from ACT to RD/WR on the same bank.
REQ-002 Ports SHALL be:
- cpu_clk  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CKE  in  1  clock enable; when 0, commands are ignored and counters/bursts still run.
- CS_N, RAS_N, CAS_N, WE_N  in  1 each  command strobes.
- BA  in  3  bank address.
- ADDR  in  15  row (ACT) or column (RD/WR) address; ADDR[10] = precharge-all on PRE.
- DQ_IN  in  8  write data, one byte per cycle.
- DQ_OUT  out  8  read data, one byte per cycle.
- DQ_OE  out  1  high while DQ_OUT carries a valid read beat.
- BANK_OPEN  out  8  per-bank row-open flags.
- MR0  out  15  last mode register value loaded.
- ERR  out  1  sticky protocol-violation flag.

Function
REQ-003 Commands SHALL be decoded when CKE=1 and CS_N=0, as {RAS_N,CAS_N,WE_N}:
- 111 NOP; 011 ACT; 101 RD; 100 WR; 010 PRE; 001 REF; 000 MRS.
- CS_N=1 SHALL be a deselect, treated as NOP.
REQ-004 ACT to a closed bank SHALL set BANK_OPEN[BA], store ADDR as that bank's open row, and load that bank's tRCD counter with TRCD.
REQ-005 ACT to an already-open bank SHALL set ERR and change no state.
REQ-006 PRE with ADDR[10]=0 SHALL clear BANK_OPEN[BA]; PRE with ADDR[10]=1 SHALL clear all BANK_OPEN bits; PRE to an already-closed bank is legal and has no effect.
REQ-007 REF and MRS SHALL be legal only when BANK_OPEN==0 and the data engine is IDLE; otherwise ERR sets and the command is ignored.
REQ-008 MRS with BA=0 SHALL load MR0<=ADDR; MRS with BA!=0 SHALL be accepted and change nothing.
REQ-009 The data engine SHALL have states IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST, with one column command outstanding at a time.
REQ-010 RD/WR SHALL be accepted only if all hold: engine IDLE, BANK_OPEN[BA]=1, that bank's tRCD counter is 0. Otherwise ERR sets and the command is ignored.
REQ-011 Burst index SHALL be {BA, ADDR[6:3]} (128 bursts x 8 bytes); ADDR[2:0] is ignored; beats run sequentially 0..7.
REQ-012 RD accepted at edge t SHALL drive DQ_OE=1 with beats 0..7 on DQ_OUT during cycles t+CL through t+CL+7, then return to IDLE.
- DQ_OE=0 and DQ_OUT=0 at all other times.
REQ-013 WR accepted at edge t SHALL sample DQ_IN at edges t+CWL through t+CWL+7 into beats 0..7, then return to IDLE.
- Each beat is committed to the array as it is sampled.
REQ-014 PRE (single or all) hitting the bank of an in-flight burst SHALL set ERR; the burst SHALL complete unaffected, and the close still takes effect.
REQ-015 The earliest legal next RD/WR is the edge immediately after the last beat; a read of a burst written by an immediately preceding WR SHALL return the new data.
REQ-016 The tRCD counters SHALL decrement by 1 per cycle, saturate at 0, and be independent per bank.
REQ-017 ERR SHALL remain set until RESET; a violating command has no other effect.

Reset
REQ-018 RESET=1 SHALL asynchronously force:
- BANK_OPEN=0, MR0=0, ERR=0, DQ_OE=0, DQ_OUT=0;
- engine IDLE, all tRCD counters 0.
REQ-019 Storage array contents SHALL NOT be reset. A burst in progress when RESET asserts is aborted; a partially written burst retains the beats already committed.

Verification
REQ-020 ACT BA=2 row 0x1A5 at t -> BANK_OPEN=0x04; RD BA=2 at t+2 -> ERR=1, DQ_OE stays 0.
REQ-021 ACT BA=1, WR BA=1 col 0x18 at t+4 with DQ_IN=0x10..0x17 at t+9..t+16, then RD same col at t+17 -> DQ_OE=1, DQ_OUT=0x10..0x17 at t+22..t+29.
REQ-022 RD accepted, second RD 3 cycles later -> ERR=1, exactly 8 DQ_OE cycles observed.
REQ-023 Banks 0 and 5 open, PRE ADDR[10]=1 -> BANK_OPEN=0; then MRS BA=0 ADDR=0x0A31 -> MR0=0x0A31, ERR=0.
REQ-024 RESET asserted at beat 3 of a read -> DQ_OE=0 immediately, BANK_OPEN=0, ERR=0; re-open and read the same burst -> original data.
REQ-025 CKE=0 with an ACT on the command bus -> BANK_OPEN unchanged, ERR=0.
